// File: rtl/pcie_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through or registered read, level flags
// and one-cycle overflow/underflow pulses. Storage itself is never reset.
module pcie_sync_fifo #(
  parameter int dbits         = 73,
  parameter int log2_depth    = 4,
  parameter int fwft          = 1,
  parameter int afull_thresh  = (1 << log2_depth) - 2,
  parameter int aempty_thresh = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [dbits-1:0]      i_wdata,
  input  logic                  i_rd_en,
  output logic [dbits-1:0]      o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [log2_depth:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int DEPTH = 1 << log2_depth;
  localparam int CW    = log2_depth + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(afull_thresh);
  localparam logic [CW-1:0] AEMPTY_C = CW'(aempty_thresh);

  logic [log2_depth-1:0] wr_ptr_q, wr_ptr_d;
  logic [log2_depth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [dbits-1:0]      mem_q [DEPTH];
  logic                  wr_acc, rd_acc;
  logic                  full, empty;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Flush wins over any same-cycle access and suppresses the error pulses.
  always_comb begin
    wr_acc      = i_wr_en & ~full & ~i_flush;
    rd_acc      = i_rd_en & ~empty & ~i_flush;
    overflow_d  = i_wr_en & ~wr_acc & ~i_flush;
    underflow_d = i_rd_en & ~rd_acc & ~i_flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_wdata;
  end

  if (fwft != 0) begin : g_fwft
    assign o_rdata = empty ? '0 : mem_q[rd_ptr_q];
  end else begin : g_reg
    logic [dbits-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (i_flush)     rdata_d = '0;
      else if (rd_acc) rdata_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) rdata_q <= '0;
      else       rdata_q <= rdata_d;
    end

    assign o_rdata = rdata_q;
  end

  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (count_q >= AFULL_C);
  assign o_almost_empty = (count_q <= AEMPTY_C);
  assign o_count        = count_q;
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_pcie_sync_fifo.sv
// Directed bench for pcie_sync_fifo: a default FWFT instance (depth 16, 73 bits)
// and a small registered-read instance (depth 4, 8 bits).
module tb_pcie_sync_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          pass_cnt = 0;
  int          check_cnt = 0;

  logic        flush, wr_en, rd_en;
  logic [72:0] wdata, rdata;
  logic        full, empty, af, ae, ovf, udf;
  logic [4:0]  count;

  logic        flush2, wr2, rd2;
  logic [7:0]  wdata2, rdata2;
  logic        full2, empty2, af2, ae2, ovf2, udf2;
  logic [2:0]  count2;

  always #5 clk = ~clk;

  pcie_sync_fifo u_dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en), .i_wdata(wdata),
    .i_rd_en(rd_en), .o_rdata(rdata), .o_full(full), .o_empty(empty),
    .o_almost_full(af), .o_almost_empty(ae), .o_count(count),
    .o_overflow(ovf), .o_underflow(udf)
  );

  pcie_sync_fifo #(.dbits(8), .log2_depth(2), .fwft(0)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush2), .i_wr_en(wr2), .i_wdata(wdata2),
    .i_rd_en(rd2), .o_rdata(rdata2), .o_full(full2), .o_empty(empty2),
    .o_almost_full(af2), .o_almost_empty(ae2), .o_count(count2),
    .o_overflow(ovf2), .o_underflow(udf2)
  );

  task automatic drive_cycle(input logic w, input logic [72:0] d, input logic r, input logic f);
    @(negedge clk);
    wr_en = w; wdata = d; rd_en = r; flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle2(input logic w, input logic [7:0] d, input logic r, input logic f);
    @(negedge clk);
    wr2 = w; wdata2 = d; rd2 = r; flush2 = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    flush = 0; wr_en = 0; rd_en = 0; wdata = '0;
    flush2 = 0; wr2 = 0; rd2 = 0; wdata2 = '0;
    @(posedge clk); @(posedge clk); #1;
    check_cnt++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty got %b want 1", empty); else pass_cnt++;
    check_cnt++; if (full !== 1'b0) $display("[TB] FAIL reset_full got %b want 0", full); else pass_cnt++;
    check_cnt++; if (count !== 5'd0) $display("[TB] FAIL reset_count got %0d want 0", count); else pass_cnt++;
    check_cnt++; if (ae !== 1'b1 || af !== 1'b0) $display("[TB] FAIL reset_flags got ae=%b af=%b want ae=1 af=0", ae, af); else pass_cnt++;
    check_cnt++; if (ovf !== 1'b0 || udf !== 1'b0) $display("[TB] FAIL reset_pulses got ovf=%b udf=%b want 0 0", ovf, udf); else pass_cnt++;
    check_cnt++; if (rdata !== 73'h0) $display("[TB] FAIL reset_rdata got %h want 0", rdata); else pass_cnt++;
    check_cnt++; if (rdata2 !== 8'h0 || empty2 !== 1'b1) $display("[TB] FAIL reset_dut2 got rdata=%h empty=%b want 0 1", rdata2, empty2); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 16; i++) begin
      drive_cycle(1'b1, 73'(i), 1'b0, 1'b0);
      check_cnt++; if (count !== 5'(i)) $display("[TB] FAIL fill_count got %0d want %0d", count, i); else pass_cnt++;
      check_cnt++; if (af !== (i >= 14)) $display("[TB] FAIL fill_afull at %0d got %b want %b", i, af, (i >= 14)); else pass_cnt++;
      check_cnt++; if (full !== (i == 16)) $display("[TB] FAIL fill_full at %0d got %b want %b", i, full, (i == 16)); else pass_cnt++;
      check_cnt++; if (rdata !== 73'h1) $display("[TB] FAIL fill_head at %0d got %h want 1", i, rdata); else pass_cnt++;
    end
  endtask

  task automatic test_overflow;
    drive_cycle(1'b1, 73'hAA, 1'b0, 1'b0);
    check_cnt++; if (ovf !== 1'b1) $display("[TB] FAIL ovf_pulse got %b want 1", ovf); else pass_cnt++;
    check_cnt++; if (count !== 5'd16) $display("[TB] FAIL ovf_count got %0d want 16", count); else pass_cnt++;
    check_cnt++; if (rdata !== 73'h1) $display("[TB] FAIL ovf_head got %h want 1", rdata); else pass_cnt++;
    drive_cycle(1'b0, 73'h0, 1'b0, 1'b0);
    check_cnt++; if (ovf !== 1'b0) $display("[TB] FAIL ovf_clear got %b want 0", ovf); else pass_cnt++;
  endtask

  task automatic test_full_rw;
    drive_cycle(1'b1, 73'hBB, 1'b1, 1'b0);
    check_cnt++; if (count !== 5'd15) $display("[TB] FAIL fullrw_count got %0d want 15", count); else pass_cnt++;
    check_cnt++; if (ovf !== 1'b1) $display("[TB] FAIL fullrw_ovf got %b want 1", ovf); else pass_cnt++;
    check_cnt++; if (full !== 1'b0) $display("[TB] FAIL fullrw_full got %b want 0", full); else pass_cnt++;
    for (int i = 2; i <= 16; i++) begin
      check_cnt++; if (rdata !== 73'(i)) $display("[TB] FAIL drain_data got %h want %h", rdata, 73'(i)); else pass_cnt++;
      drive_cycle(1'b0, 73'h0, 1'b1, 1'b0);
    end
    check_cnt++; if (empty !== 1'b1 || count !== 5'd0) $display("[TB] FAIL drain_empty got empty=%b count=%0d want 1 0", empty, count); else pass_cnt++;
    check_cnt++; if (rdata !== 73'h0) $display("[TB] FAIL drain_rdata got %h want 0", rdata); else pass_cnt++;
    check_cnt++; if (ovf !== 1'b0) $display("[TB] FAIL drain_ovf got %b want 0", ovf); else pass_cnt++;
  endtask

  task automatic test_underflow;
    drive_cycle(1'b0, 73'h0, 1'b1, 1'b0);
    check_cnt++; if (udf !== 1'b1) $display("[TB] FAIL udf_pulse got %b want 1", udf); else pass_cnt++;
    check_cnt++; if (rdata !== 73'h0 || count !== 5'd0) $display("[TB] FAIL udf_state got rdata=%h count=%0d want 0 0", rdata, count); else pass_cnt++;
    drive_cycle(1'b0, 73'h0, 1'b0, 1'b0);
    check_cnt++; if (udf !== 1'b0) $display("[TB] FAIL udf_clear got %b want 0", udf); else pass_cnt++;
  endtask

  task automatic test_empty_rw;
    drive_cycle(1'b1, 73'h5A5, 1'b1, 1'b0);
    check_cnt++; if (count !== 5'd1) $display("[TB] FAIL emptyrw_count got %0d want 1", count); else pass_cnt++;
    check_cnt++; if (udf !== 1'b1 || ovf !== 1'b0) $display("[TB] FAIL emptyrw_pulses got udf=%b ovf=%b want 1 0", udf, ovf); else pass_cnt++;
    check_cnt++; if (rdata !== 73'h5A5) $display("[TB] FAIL emptyrw_data got %h want 5a5", rdata); else pass_cnt++;
    drive_cycle(1'b0, 73'h0, 1'b1, 1'b0);
    check_cnt++; if (empty !== 1'b1 || udf !== 1'b0) $display("[TB] FAIL emptyrw_drain got empty=%b udf=%b want 1 0", empty, udf); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [72:0] exp_q[$];
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 73'(100 + i), 1'b0, 1'b0);
      exp_q.push_back(73'(100 + i));
    end
    for (int c = 0; c < 40; c++) begin
      check_cnt++; if (rdata !== exp_q[0]) $display("[TB] FAIL stream_data cycle %0d got %h want %h", c, rdata, exp_q[0]); else pass_cnt++;
      drive_cycle(1'b1, 73'(200 + c), 1'b1, 1'b0);
      void'(exp_q.pop_front());
      exp_q.push_back(73'(200 + c));
      check_cnt++; if (count !== 5'd4) $display("[TB] FAIL stream_count cycle %0d got %0d want 4", c, count); else pass_cnt++;
    end
    check_cnt++; if (rdata !== 73'd236) $display("[TB] FAIL stream_tail got %h want %h", rdata, 73'd236); else pass_cnt++;
  endtask

  task automatic test_flush;
    drive_cycle(1'b1, 73'd300, 1'b0, 1'b0);
    check_cnt++; if (count !== 5'd5) $display("[TB] FAIL flush_pre got %0d want 5", count); else pass_cnt++;
    drive_cycle(1'b1, 73'h777, 1'b1, 1'b1);
    check_cnt++; if (count !== 5'd0 || empty !== 1'b1) $display("[TB] FAIL flush_clear got count=%0d empty=%b want 0 1", count, empty); else pass_cnt++;
    check_cnt++; if (ovf !== 1'b0 || udf !== 1'b0) $display("[TB] FAIL flush_pulses got ovf=%b udf=%b want 0 0", ovf, udf); else pass_cnt++;
    check_cnt++; if (rdata !== 73'h0) $display("[TB] FAIL flush_rdata got %h want 0", rdata); else pass_cnt++;
    drive_cycle(1'b1, 73'h123, 1'b0, 1'b0);
    check_cnt++; if (count !== 5'd1 || rdata !== 73'h123) $display("[TB] FAIL flush_after got count=%0d rdata=%h want 1 123", count, rdata); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    drive_cycle(1'b1, 73'h456, 1'b0, 1'b0);
    drive_cycle(1'b1, 73'h789, 1'b0, 1'b0);
    check_cnt++; if (count !== 5'd3) $display("[TB] FAIL arst_pre got %0d want 3", count); else pass_cnt++;
    @(negedge clk);
    wr_en = 1'b1; wdata = 73'h999; rd_en = 1'b0; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_cnt++; if (empty !== 1'b1 || count !== 5'd0) $display("[TB] FAIL arst_now got empty=%b count=%0d want 1 0", empty, count); else pass_cnt++;
    check_cnt++; if (rdata !== 73'h0 || ae !== 1'b1) $display("[TB] FAIL arst_out got rdata=%h ae=%b want 0 1", rdata, ae); else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++; if (count !== 5'd0) $display("[TB] FAIL arst_hold got %0d want 0", count); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b1; wdata = 73'hABC;
    @(posedge clk); #1;
    check_cnt++; if (count !== 5'd1 || rdata !== 73'hABC) $display("[TB] FAIL arst_first got count=%0d rdata=%h want 1 abc", count, rdata); else pass_cnt++;
    drive_cycle(1'b0, 73'h0, 1'b0, 1'b0);
  endtask

  task automatic test_registered_read;
    drive_cycle2(1'b1, 8'hA1, 1'b0, 1'b0);
    drive_cycle2(1'b1, 8'hB2, 1'b0, 1'b0);
    check_cnt++; if (count2 !== 3'd2 || rdata2 !== 8'h0) $display("[TB] FAIL reg_load got count=%0d rdata=%h want 2 0", count2, rdata2); else pass_cnt++;
    check_cnt++; if (af2 !== 1'b1) $display("[TB] FAIL reg_afull got %b want 1", af2); else pass_cnt++;
    drive_cycle2(1'b0, 8'h0, 1'b1, 1'b0);
    check_cnt++; if (rdata2 !== 8'hA1 || count2 !== 3'd1) $display("[TB] FAIL reg_read1 got rdata=%h count=%0d want a1 1", rdata2, count2); else pass_cnt++;
    drive_cycle2(1'b0, 8'h0, 1'b1, 1'b0);
    check_cnt++; if (rdata2 !== 8'hB2 || empty2 !== 1'b1) $display("[TB] FAIL reg_read2 got rdata=%h empty=%b want b2 1", rdata2, empty2); else pass_cnt++;
    drive_cycle2(1'b0, 8'h0, 1'b1, 1'b0);
    check_cnt++; if (udf2 !== 1'b1 || rdata2 !== 8'hB2) $display("[TB] FAIL reg_udf got udf=%b rdata=%h want 1 b2", udf2, rdata2); else pass_cnt++;
    drive_cycle2(1'b0, 8'h0, 1'b0, 1'b1);
    check_cnt++; if (rdata2 !== 8'h0 || udf2 !== 1'b0) $display("[TB] FAIL reg_flush got rdata=%h udf=%b want 0 0", rdata2, udf2); else pass_cnt++;
    for (int i = 0; i < 4; i++) drive_cycle2(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    check_cnt++; if (full2 !== 1'b1 || count2 !== 3'd4) $display("[TB] FAIL reg_full got full=%b count=%0d want 1 4", full2, count2); else pass_cnt++;
    drive_cycle2(1'b0, 8'h0, 1'b1, 1'b0);
    check_cnt++; if (rdata2 !== 8'h10) $display("[TB] FAIL reg_head got %h want 10", rdata2); else pass_cnt++;
    drive_cycle2(1'b0, 8'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_empty_rw();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_registered_read();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
